hilo_div_ctrl: RTL and testbench

- Sequences all writes into the HI/LO register pair.
- Runs an iterative radix-2 restoring divider for DIV/DIVU and stalls the pipeline while it runs.
- Merges MTHI/MTLO writes into the single HI/LO write port.
- Sits in the EX stage and drives the HI/LO register's write enable and data inputs.

---
 rtl/hilo_div_ctrl_pkg.sv | 14 +
 rtl/hilo_div_ctrl_div_step.sv | 25 ++
 rtl/hilo_div_ctrl.sv | 174 +++++++++++++++++
 tb/tb_hilo_div_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_div_ctrl_pkg.sv
// Shared types and constants for the HI/LO write sequencer and its iterative divider.
package hilo_div_ctrl_pkg;

  localparam int unsigned DIV_DATA_W = 32;
  localparam int unsigned DIV_ITER   = 32;
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_CALC,
    DIV_DONE
  } div_state_t;

endpackage

// File: rtl/hilo_div_ctrl_div_step.sv
// One radix-2 restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module hilo_div_ctrl_div_step #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W:0]   rem_i,
  input  logic [DATA_W-1:0] divisor_i,
  input  logic              bit_i,
  output logic [DATA_W:0]   rem_o,
  output logic              q_o
);

  localparam int unsigned EXT_W = DATA_W + 2;

  logic [EXT_W-1:0] shifted;
  logic [EXT_W-1:0] diff;

  // The extra top bit of diff acts as the borrow of the trial subtraction.
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - EXT_W'(divisor_i);
    q_o     = ~diff[EXT_W-1];
    rem_o   = q_o ? diff[DATA_W:0] : shifted[DATA_W:0];
  end

endmodule

// File: rtl/hilo_div_ctrl.sv
// EX-stage HI/LO write sequencer: iterative DIV/DIVU with pipeline stall, merged with MTHI/MTLO writes.
module hilo_div_ctrl
  import hilo_div_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DIV_DATA_W,
  parameter int unsigned ITER   = DIV_ITER
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              signed_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  input  logic              cancel_i,
  input  logic              mthi_i,
  input  logic              mtlo_i,
  input  logic [DATA_W-1:0] mt_data_i,
  input  logic [DATA_W-1:0] hi_cur_i,
  input  logic [DATA_W-1:0] lo_cur_i,
  output logic              stall_o,
  output logic              busy_o,
  output logic              hilo_we_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              div_zero_o
);

  localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int unsigned REM_W = DATA_W + 1;

  div_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic              sgn_q, sgn_d;
  logic              sd_q, sd_d;
  logic              sv_q, sv_d;
  logic              dz_q, dz_d;

  logic [REM_W-1:0]  step_rem;
  logic              step_q;
  logic [DATA_W-1:0] dvd_mag;
  logic [DATA_W-1:0] dvs_mag;
  logic [DATA_W-1:0] q_fix;
  logic [DATA_W-1:0] r_fix;

  // quo_q doubles as the dividend shift register: its MSB feeds each step.
  hilo_div_ctrl_div_step #(.DATA_W(DATA_W)) u_div_step (
    .rem_i     (rem_q),
    .divisor_i (dvs_q),
    .bit_i     (quo_q[DATA_W-1]),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      sgn_q   <= 1'b0;
      sd_q    <= 1'b0;
      sv_q    <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      sgn_q   <= sgn_d;
      sd_q    <= sd_d;
      sv_q    <= sv_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    sgn_d      = sgn_q;
    sd_d       = sd_q;
    sv_d       = sv_q;
    dz_d       = dz_q;
    stall_o    = 1'b0;
    busy_o     = 1'b0;
    hilo_we_o  = 1'b0;
    hi_o       = '0;
    lo_o       = '0;
    div_zero_o = 1'b0;

    // 0x80000000 negates to itself, which is its correct unsigned magnitude.
    dvd_mag = (signed_i && dividend_i[DATA_W-1]) ? (~dividend_i + DATA_W'(1)) : dividend_i;
    dvs_mag = (signed_i && divisor_i[DATA_W-1])  ? (~divisor_i + DATA_W'(1))  : divisor_i;

    // Divide-by-zero results are delivered raw, without sign correction.
    q_fix = quo_q;
    r_fix = rem_q[DATA_W-1:0];
    if (!dz_q && sgn_q && (sd_q ^ sv_q)) q_fix = ~quo_q + DATA_W'(1);
    if (!dz_q && sgn_q && sd_q)          r_fix = ~rem_q[DATA_W-1:0] + DATA_W'(1);

    unique case (state_q)
      DIV_IDLE: begin
        if (start_i && !cancel_i) begin
          stall_o = 1'b1;
          sgn_d   = signed_i;
          sd_d    = signed_i & dividend_i[DATA_W-1];
          sv_d    = signed_i & divisor_i[DATA_W-1];
          dvs_d   = dvs_mag;
          cnt_d   = '0;
          if (divisor_i == '0) begin
            state_d = DIV_DONE;
            dz_d    = 1'b1;
            quo_d   = DATA_W'(DIV_ZERO_Q);
            rem_d   = {1'b0, dividend_i};
          end else begin
            state_d = DIV_CALC;
            dz_d    = 1'b0;
            quo_d   = dvd_mag;
            rem_d   = '0;
          end
        end
        if (mthi_i || mtlo_i) begin
          hilo_we_o = 1'b1;
          hi_o      = mthi_i ? mt_data_i : hi_cur_i;
          lo_o      = mtlo_i ? mt_data_i : lo_cur_i;
        end
      end
      DIV_CALC: begin
        stall_o = 1'b1;
        busy_o  = 1'b1;
        rem_d   = step_rem;
        quo_d   = {quo_q[DATA_W-2:0], step_q};
        if (cancel_i) begin
          state_d = DIV_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(ITER - 1)) begin
          state_d = DIV_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DIV_DONE: begin
        busy_o  = 1'b1;
        state_d = DIV_IDLE;
        if (!cancel_i) begin
          hilo_we_o  = 1'b1;
          hi_o       = r_fix;
          lo_o       = q_fix;
          div_zero_o = dz_q;
        end
      end
      default: state_d = DIV_IDLE;
    endcase

    // Outputs are combinational, so hold them quiet while reset is asserted.
    if (!rst) begin
      stall_o    = 1'b0;
      busy_o     = 1'b0;
      hilo_we_o  = 1'b0;
      hi_o       = '0;
      lo_o       = '0;
      div_zero_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Randomized and directed bench for hilo_div_ctrl against an arithmetic reference model.
module tb_hilo_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, signed_i, cancel_i, mthi_i, mtlo_i;
  logic [31:0] dividend_i, divisor_i, mt_data_i, hi_cur_i, lo_cur_i;
  logic        stall_o, busy_o, hilo_we_o, div_zero_o;
  logic [31:0] hi_o, lo_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hilo_div_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .cancel_i   (cancel_i),
    .mthi_i     (mthi_i),
    .mtlo_i     (mtlo_i),
    .mt_data_i  (mt_data_i),
    .hi_cur_i   (hi_cur_i),
    .lo_cur_i   (lo_cur_i),
    .stall_o    (stall_o),
    .busy_o     (busy_o),
    .hilo_we_o  (hilo_we_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .div_zero_o (div_zero_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // MIPS semantics via magnitudes: quotient truncates toward zero, remainder follows dividend.
  function automatic void ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    logic [31:0] ma, mb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      return;
    end
    ma = (sgn && a[31]) ? 32'd0 - a : a;
    mb = (sgn && b[31]) ? 32'd0 - b : b;
    q  = ma / mb;
    r  = ma % mb;
    if (sgn && (a[31] ^ b[31])) q = 32'd0 - q;
    if (sgn && a[31])           r = 32'd0 - r;
  endfunction

  task automatic idle_inputs();
    start_i = 1'b0; signed_i = 1'b0; cancel_i = 1'b0; mthi_i = 1'b0; mtlo_i = 1'b0;
    dividend_i = '0; divisor_i = '0; mt_data_i = '0; hi_cur_i = '0; lo_cur_i = '0;
  endtask

  // Full divide transaction: accept (cycle 0), CALC, write cycle, back to idle.
  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er,
                        input logic mth, input logic mtl, input logic kill_done, input string tag);
    int wc;
    logic [31:0] mhi, mlo;
    logic mt;
    wc = (b == 32'd0) ? 1 : 33;
    mt = mth | mtl;
    @(negedge clk);
    start_i = 1'b1; signed_i = sgn; dividend_i = a; divisor_i = b; cancel_i = 1'b0;
    mthi_i = mth; mtlo_i = mtl; mt_data_i = $urandom; hi_cur_i = $urandom; lo_cur_i = $urandom;
    mhi = mth ? mt_data_i : hi_cur_i;
    mlo = mtl ? mt_data_i : lo_cur_i;
    #1;
    check({tag, ":acc_ctl"}, {stall_o, busy_o, hilo_we_o, div_zero_o}, {3'b10_0 | {2'b00, mt}, 1'b0});
    check({tag, ":acc_hi"}, hi_o, mt ? mhi : 32'd0);
    check({tag, ":acc_lo"}, lo_o, mt ? mlo : 32'd0);
    for (int c = 1; c < wc; c++) begin
      @(negedge clk);
      start_i = 1'($urandom); signed_i = 1'($urandom); mthi_i = 1'($urandom); mtlo_i = 1'($urandom);
      dividend_i = $urandom; divisor_i = $urandom; mt_data_i = $urandom;
      #1;
      check({tag, ":calc_ctl"}, {stall_o, busy_o, hilo_we_o, div_zero_o}, 4'b1100);
    end
    @(negedge clk);
    start_i = 1'b0; cancel_i = kill_done; mthi_i = 1'($urandom); mtlo_i = 1'($urandom);
    #1;
    check({tag, ":wr_ctl"}, {stall_o, busy_o, hilo_we_o, div_zero_o},
          {2'b01, ~kill_done, ~kill_done & (b == 32'd0)});
    check({tag, ":wr_lo"}, lo_o, kill_done ? 32'd0 : eq);
    check({tag, ":wr_hi"}, hi_o, kill_done ? 32'd0 : er);
    @(negedge clk);
    idle_inputs();
    #1;
    check({tag, ":post"}, {stall_o, busy_o, hilo_we_o, div_zero_o}, 4'b0000);
  endtask

  initial begin
    logic [31:0] a, b, eq, er;
    logic        sgn;

    idle_inputs();
    rst = 1'b0;
    mthi_i = 1'b1; start_i = 1'b1; mt_data_i = 32'h1234_5678;
    @(negedge clk); #1;
    check("reset_ctl", {stall_o, busy_o, hilo_we_o, div_zero_o}, 4'b0000);
    check("reset_hi", hi_o, 32'd0);
    check("reset_lo", lo_o, 32'd0);
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;

    // Directed divides with hand-computed results.
    do_div(1'b0, 32'd7, 32'd2, 32'd3, 32'd1, 1'b0, 1'b0, 1'b0, "divu_7_2");
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, "div_m7_2");
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b0, 1'b0, "div_min_m1");
    do_div(1'b0, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b0, 1'b0, 1'b0, "divu_zero");
    do_div(1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0, 1'b0, 1'b0, "div_zero_neg");
    do_div(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 1'b0, "divu_max_mthi");
    do_div(1'b0, 32'd7, 32'd2, 32'd3, 32'd1, 1'b0, 1'b0, 1'b1, "cancel_done");
    do_div(1'b0, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9, 1'b0, 1'b0, 1'b1, "cancel_dz");

    // MT writes in IDLE.
    @(negedge clk);
    mthi_i = 1'b1; mt_data_i = 32'hDEAD_BEEF; lo_cur_i = 32'h5; hi_cur_i = 32'h1111_2222; #1;
    check("mthi_ctl", {stall_o, busy_o, hilo_we_o}, 3'b001);
    check("mthi_hi", hi_o, 32'hDEAD_BEEF);
    check("mthi_lo", lo_o, 32'h5);
    @(negedge clk);
    mthi_i = 1'b0; mtlo_i = 1'b1; #1;
    check("mtlo_hi", hi_o, 32'h1111_2222);
    check("mtlo_lo", lo_o, 32'hDEAD_BEEF);
    @(negedge clk);
    mthi_i = 1'b1; #1;
    check("mtboth_hi", hi_o, 32'hDEAD_BEEF);
    check("mtboth_lo", lo_o, 32'hDEAD_BEEF);
    @(negedge clk);
    idle_inputs(); #1;
    check("mt_off", {hilo_we_o, hi_o[0], lo_o[0]}, 3'b000);

    // Start rejected by a simultaneous cancel.
    @(negedge clk);
    start_i = 1'b1; cancel_i = 1'b1; divisor_i = 32'd5; dividend_i = 32'd50; #1;
    check("idle_cancel_stall", stall_o, 1'b0);
    @(negedge clk);
    idle_inputs(); #1;
    check("idle_cancel_busy", busy_o, 1'b0);

    // Cancel during CALC at cycle 10; MTHI during CALC must be ignored.
    @(negedge clk);
    start_i = 1'b1; dividend_i = 32'd100; divisor_i = 32'd3; #1;
    check("cc_acc_stall", stall_o, 1'b1);
    for (int c = 1; c < 10; c++) begin
      @(negedge clk);
      start_i = 1'b0; mthi_i = 1'b1; mt_data_i = 32'hDEAD_BEEF; #1;
      check("cc_calc", {stall_o, busy_o, hilo_we_o, hi_o}, {3'b110, 32'd0});
    end
    @(negedge clk);
    mthi_i = 1'b0; cancel_i = 1'b1; #1;
    check("cc_cancel", {busy_o, hilo_we_o}, 2'b10);
    for (int c = 11; c <= 40; c++) begin
      @(negedge clk);
      cancel_i = 1'b0; #1;
      check("cc_after", {stall_o, busy_o, hilo_we_o, div_zero_o}, 4'b0000);
    end

    // Reset pulsed at cycle 20 of a running divide.
    @(negedge clk);
    start_i = 1'b1; dividend_i = 32'd100; divisor_i = 32'd3; #1;
    check("rr_acc_stall", stall_o, 1'b1);
    for (int c = 1; c < 20; c++) begin
      @(negedge clk);
      start_i = 1'b0; #1;
      check("rr_calc", {stall_o, busy_o, hilo_we_o}, 3'b110);
    end
    @(negedge clk);
    rst = 1'b0; start_i = 1'b1; mthi_i = 1'b1; mtlo_i = 1'b1; mt_data_i = 32'hCAFE_F00D; #1;
    check("rr_ctl", {stall_o, busy_o, hilo_we_o, div_zero_o}, 4'b0000);
    check("rr_hi", hi_o, 32'd0);
    check("rr_lo", lo_o, 32'd0);
    @(negedge clk);
    idle_inputs();
    rst = 1'b1; #1;
    check("rr_release", {stall_o, busy_o, hilo_we_o}, 3'b000);
    for (int c = 22; c <= 40; c++) begin
      @(negedge clk); #1;
      check("rr_after", {busy_o, hilo_we_o}, 2'b00);
    end

    // Randomized divides checked against the reference model.
    for (int i = 0; i < 24; i++) begin
      sgn = 1'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(1, 15);
        3:       b = 32'h8000_0000;
        default: b = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       a = 32'h8000_0000;
        1:       a = $urandom_range(0, 20);
        default: a = $urandom;
      endcase
      ref_div(sgn, a, b, eq, er);
      do_div(sgn, a, b, eq, er, 1'($urandom), 1'($urandom), 1'b0, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
